// File: rtl/eth_pkt_pkg.sv
// Shared types for the Ethernet store-and-forward packet buffer:
// stored beat layout, input FSM states and a saturating counter helper.
package eth_pkt_pkg;

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [7:0] data;
    } beat_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RECV    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/eth_pkt_mem.sv
// Beat storage: register array with one synchronous write port and one
// asynchronous read port; contents are not reset.
module eth_pkt_mem
    import eth_pkt_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  beat_t         wbeat,
    input  logic [AW-1:0] raddr,
    output beat_t         rbeat
);

    beat_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wbeat;
        end
    end

    assign rbeat = mem[raddr];

endmodule

// File: rtl/eth_pkt_buffer.sv
// Store-and-forward byte packet buffer: packets become visible downstream only
// once their eop byte is written; truncated or oversized packets are dropped.
module eth_pkt_buffer
    import eth_pkt_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_sop,
    input  logic        in_eop,
    input  logic        in_srdy,
    output logic        in_drdy,
    output logic [7:0]  out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic        out_srdy,
    input  logic        out_drdy,
    output logic [15:0] drop_cnt,
    output logic [15:0] pkt_cnt
);

    typedef logic [AW:0] ptr_t;

    localparam ptr_t PTR_ONE   = ptr_t'(1);
    localparam ptr_t PTR_DEPTH = ptr_t'(DEPTH);

    state_t        state;
    ptr_t          wr_ptr;
    ptr_t          wr_commit;
    ptr_t          rd_ptr;
    ptr_t          fill;
    logic          full;
    logic          in_xfer;
    logic          out_xfer;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    beat_t         mem_wbeat;
    beat_t         mem_rbeat;

    assign fill     = wr_ptr - rd_ptr;
    assign full     = (fill == PTR_DEPTH);
    assign out_srdy = (rd_ptr != wr_commit);
    assign in_drdy  = (state != S_RECV) || !full;
    assign in_xfer  = in_srdy && in_drdy;
    assign out_xfer = out_srdy && out_drdy;

    assign out_data = mem_rbeat.data;
    assign out_sop  = mem_rbeat.sop;
    assign out_eop  = mem_rbeat.eop;

    // A sop arriving in RECV restarts the packet at wr_commit, so the write
    // lands there rather than at the (about to be rewound) wr_ptr.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_ptr[AW-1:0];
        mem_wbeat = '{sop: in_sop, eop: in_eop, data: in_data};
        case (state)
            S_IDLE, S_DISCARD: begin
                if (in_xfer && in_sop && !full) begin
                    mem_we = 1'b1;
                end
            end
            S_RECV: begin
                if (in_xfer) begin
                    mem_we = 1'b1;
                    if (in_sop) begin
                        mem_waddr = wr_commit[AW-1:0];
                    end
                end
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            wr_commit <= '0;
            rd_ptr    <= '0;
            drop_cnt  <= '0;
            pkt_cnt   <= '0;
        end else begin
            if (out_xfer) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case (state)
                S_IDLE, S_DISCARD: begin
                    if (in_xfer) begin
                        if (in_sop) begin
                            if (full) begin
                                // No room for even the first byte; committed data is kept.
                                drop_cnt <= sat_inc16(drop_cnt);
                                state    <= in_eop ? S_IDLE : S_DISCARD;
                            end else if (in_eop) begin
                                wr_ptr    <= wr_ptr + PTR_ONE;
                                wr_commit <= wr_ptr + PTR_ONE;
                                pkt_cnt   <= pkt_cnt + 16'd1;
                                state     <= S_IDLE;
                            end else begin
                                wr_ptr <= wr_ptr + PTR_ONE;
                                state  <= S_RECV;
                            end
                        end else if (in_eop && state == S_DISCARD) begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_RECV: begin
                    if (full && wr_commit == rd_ptr) begin
                        wr_ptr   <= wr_commit;
                        drop_cnt <= sat_inc16(drop_cnt);
                        state    <= S_DISCARD;
                    end else if (in_xfer) begin
                        if (in_sop) begin
                            drop_cnt <= sat_inc16(drop_cnt);
                            wr_ptr   <= wr_commit + PTR_ONE;
                            if (in_eop) begin
                                wr_commit <= wr_commit + PTR_ONE;
                                pkt_cnt   <= pkt_cnt + 16'd1;
                                state     <= S_IDLE;
                            end
                        end else if (in_eop) begin
                            wr_ptr    <= wr_ptr + PTR_ONE;
                            wr_commit <= wr_ptr + PTR_ONE;
                            pkt_cnt   <= pkt_cnt + 16'd1;
                            state     <= S_IDLE;
                        end else begin
                            wr_ptr <= wr_ptr + PTR_ONE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    eth_pkt_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wbeat (mem_wbeat),
        .raddr (rd_ptr[AW-1:0]),
        .rbeat (mem_rbeat)
    );

endmodule
